// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding one UART TX with 32-bit words, MSB byte first
// Two word requesters share the transmitter; each grant sends up to 4 bytes and returns a done pulse.
module uart_tx_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req0,
  input  logic [31:0] i_data0,
  input  logic [2:0]  i_num0,
  output logic        o_done0,
  input  logic        i_req1,
  input  logic [31:0] i_data1,
  input  logic [2:0]  i_num1,
  output logic        o_done1,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_start,
  input  logic        i_tx_start_clear,
  input  logic        i_busy,
  output logic        o_busy,
  output logic        o_owner
);

  typedef enum logic [2:0] {
    IDLE, LOAD, WAIT_TX, SEND, WAIT_CLR, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [2:0]  num_q, num_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        busy_q, busy_d;

  logic        win;
  logic [2:0]  win_num;

  // On a tie the requester that did not finish last is favoured.
  assign win     = (i_req0 && i_req1) ? ~last_q : i_req1;
  assign win_num = win ? i_num1 : i_num0;

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    num_d      = num_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    last_d     = last_q;
    tx_data_d  = tx_data_q;
    tx_start_d = tx_start_q;
    done0_d    = 1'b0;
    done1_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req0 || i_req1) begin
          owner_d = win;
          word_d  = win ? i_data1 : i_data0;
          num_d   = (win_num > 3'd4) ? 3'd4 : win_num;
          cnt_d   = 3'd0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (num_q == 3'd0)  state_d = DONE;
        else if (!i_busy)   state_d = SEND;
        else                state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (!i_busy) state_d = SEND;
      end
      SEND: begin
        case (cnt_q[1:0])
          2'd0:    tx_data_d = word_q[31:24];
          2'd1:    tx_data_d = word_q[23:16];
          2'd2:    tx_data_d = word_q[15:8];
          default: tx_data_d = word_q[7:0];
        endcase
        tx_start_d = 1'b1;
        cnt_d      = cnt_q + 3'd1;
        state_d    = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (i_tx_start_clear) begin
          tx_start_d = 1'b0;
          tx_data_d  = 8'd0;
          state_d    = (cnt_q == num_q) ? DONE : WAIT_TX;
        end
      end
      DONE: begin
        done0_d = ~owner_q;
        done1_d = owner_q;
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      word_q     <= 32'd0;
      num_q      <= 3'd0;
      cnt_q      <= 3'd0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      tx_data_q  <= 8'd0;
      tx_start_q <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      num_q      <= num_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      busy_q     <= busy_d;
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_done0    = done0_q;
  assign o_done1    = done1_q;
  assign o_busy     = busy_q;
  assign o_owner    = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed bench for uart_tx_arbiter with byte and done scoreboards
// Inputs and sampling happen on the falling edge; the DUT acts on the rising edge.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req0, i_req1;
  logic [31:0] i_data0, i_data1;
  logic [2:0]  i_num0, i_num1;
  logic        o_done0, o_done1;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        i_tx_start_clear;
  logic        i_busy;
  logic        o_busy;
  logic        o_owner;

  int checks = 0;
  int passed = 0;
  logic clr_en;
  logic [7:0] exp_bytes[$];
  logic [1:0] exp_done[$];

  uart_tx_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req0(i_req0), .i_data0(i_data0), .i_num0(i_num0), .o_done0(o_done0),
    .i_req1(i_req1), .i_data1(i_data1), .i_num1(i_num1), .o_done1(o_done1),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
    .i_tx_start_clear(i_tx_start_clear), .i_busy(i_busy),
    .o_busy(o_busy), .o_owner(o_owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_busy(input logic v, input string tag);
    int n = 0;
    while (o_busy !== v && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(o_busy), 32'(v));
  endtask

  task automatic wait_start(input logic v, input string tag);
    int n = 0;
    while (o_tx_start !== v && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(o_tx_start), 32'(v));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  // UART model: clears each start two cycles after it appears.
  initial begin
    int cnt;
    cnt = 0;
    i_tx_start_clear = 1'b0;
    forever begin
      @(negedge clk);
      if (i_tx_start_clear) begin
        i_tx_start_clear = 1'b0;
        cnt = 0;
      end else if (clr_en && o_tx_start) begin
        cnt++;
        if (cnt >= 2) i_tx_start_clear = 1'b1;
      end else begin
        cnt = 0;
      end
    end
  end

  // Scoreboard: every start rising edge pops a byte, every done pulse pops an owner code.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (o_tx_start && !prev) begin
        if (exp_bytes.size() == 0) check("byte_unexpected", 32'(o_tx_data), 32'h100);
        else check("tx_byte", 32'(o_tx_data), 32'(exp_bytes.pop_front()));
      end
      prev = o_tx_start;
      if (o_done0 || o_done1) begin
        if (exp_done.size() == 0) check("done_unexpected", 32'({o_done1, o_done0}), 32'h0);
        else check("done_owner", 32'({o_done1, o_done0}), 32'(exp_done.pop_front()));
      end
    end
  end

  initial begin
    logic saw;
    rst = 1'b1; clr_en = 1'b1; i_busy = 1'b0;
    i_req0 = 1'b0; i_data0 = 32'd0; i_num0 = 3'd0;
    i_req1 = 1'b0; i_data1 = 32'd0; i_num1 = 3'd0;
    cyc(2);
    check("rst_tx_data", 32'(o_tx_data), 32'h0);
    check("rst_tx_start", 32'(o_tx_start), 32'h0);
    check("rst_done", 32'({o_done1, o_done0}), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_owner", 32'(o_owner), 32'h0);
    rst = 1'b0;
    cyc(1);

    // Single word, four bytes
    i_req0 = 1'b1; i_data0 = 32'hA1B2C3D4; i_num0 = 3'd4;
    exp_bytes.push_back(8'hA1); exp_bytes.push_back(8'hB2);
    exp_bytes.push_back(8'hC3); exp_bytes.push_back(8'hD4);
    exp_done.push_back(2'b01);
    cyc(1);
    check("single_busy", 32'(o_busy), 32'h1);
    check("single_owner", 32'(o_owner), 32'h0);
    i_req0 = 1'b0;
    cyc(1);
    check("single_start_early", 32'(o_tx_start), 32'h0);
    cyc(1);
    check("single_start_lat", 32'(o_tx_start), 32'h1);
    check("single_first_byte", 32'(o_tx_data), 32'hA1);
    wait_busy(1'b0, "single_end");
    check("single_bytes_sent", 32'(exp_bytes.size()), 32'h0);

    // Contention: alternate grants starting with requester 0
    do_reset();
    i_req0 = 1'b1; i_data0 = 32'hA0000000; i_num0 = 3'd1;
    i_req1 = 1'b1; i_data1 = 32'hB0000000; i_num1 = 3'd1;
    for (int i = 0; i < 4; i++) begin
      exp_bytes.push_back((i % 2 == 0) ? 8'hA0 : 8'hB0);
      exp_done.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
    end
    for (int i = 0; i < 4; i++) begin
      wait_busy(1'b1, "cont_grant");
      check("cont_owner", 32'(o_owner), 32'(i % 2));
      if (i == 3) begin
        i_req0 = 1'b0;
        i_req1 = 1'b0;
      end
      wait_busy(1'b0, "cont_end");
    end
    check("cont_dones", 32'(exp_done.size()), 32'h0);

    // Zero byte count: done without any byte
    cyc(1);
    i_req1 = 1'b1; i_num1 = 3'd0; i_data1 = 32'hFFFFFFFF;
    exp_done.push_back(2'b10);
    cyc(1);
    check("num0_owner", 32'(o_owner), 32'h1);
    i_req1 = 1'b0;
    cyc(1);
    check("num0_done_early", 32'(o_done1), 32'h0);
    cyc(1);
    check("num0_done", 32'(o_done1), 32'h1);
    check("num0_start", 32'(o_tx_start), 32'h0);
    wait_busy(1'b0, "num0_end");

    // Byte count 7 clamps to 4
    cyc(1);
    i_req1 = 1'b1; i_num1 = 3'd7; i_data1 = 32'h11223344;
    exp_bytes.push_back(8'h11); exp_bytes.push_back(8'h22);
    exp_bytes.push_back(8'h33); exp_bytes.push_back(8'h44);
    exp_done.push_back(2'b10);
    wait_busy(1'b1, "num7_grant");
    i_req1 = 1'b0;
    wait_busy(1'b0, "num7_end");
    check("num7_bytes_sent", 32'(exp_bytes.size()), 32'h0);

    // Backpressure: UART busy for 10 cycles, data changes are ignored
    cyc(1);
    i_busy = 1'b1;
    i_req0 = 1'b1; i_data0 = 32'hCAFEBABE; i_num0 = 3'd2;
    exp_bytes.push_back(8'hCA); exp_bytes.push_back(8'hFE);
    exp_done.push_back(2'b01);
    wait_busy(1'b1, "bp_grant");
    i_req0 = 1'b0; i_data0 = 32'hDEADBEEF;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (o_tx_start) saw = 1'b1;
    end
    check("bp_no_start", 32'(saw), 32'h0);
    i_busy = 1'b0;
    cyc(1);
    check("bp_start_early", 32'(o_tx_start), 32'h0);
    cyc(1);
    check("bp_start", 32'(o_tx_start), 32'h1);
    check("bp_byte", 32'(o_tx_data), 32'hCA);
    wait_busy(1'b0, "bp_end");

    // Reset while byte 2 of 4 waits for its clear
    cyc(1);
    i_req0 = 1'b1; i_data0 = 32'h55667788; i_num0 = 3'd4;
    exp_bytes.push_back(8'h55); exp_bytes.push_back(8'h66);
    wait_busy(1'b1, "mid_grant");
    i_req0 = 1'b0;
    wait_start(1'b1, "mid_byte1");
    wait_start(1'b0, "mid_byte1_clr");
    clr_en = 1'b0;
    wait_start(1'b1, "mid_byte2");
    cyc(3);
    check("mid_hold_start", 32'(o_tx_start), 32'h1);
    check("mid_hold_data", 32'(o_tx_data), 32'h66);
    rst = 1'b1;
    cyc(1);
    check("mid_rst_start", 32'(o_tx_start), 32'h0);
    check("mid_rst_busy", 32'(o_busy), 32'h0);
    check("mid_rst_data", 32'(o_tx_data), 32'h0);
    rst = 1'b0; clr_en = 1'b1;
    cyc(3);
    i_req0 = 1'b1; i_data0 = 32'h99AABBCC; i_num0 = 3'd1;
    i_req1 = 1'b1; i_data1 = 32'h12345678; i_num1 = 3'd1;
    exp_bytes.push_back(8'h99);
    exp_done.push_back(2'b01);
    wait_busy(1'b1, "fresh_grant");
    check("fresh_owner", 32'(o_owner), 32'h0);
    i_req0 = 1'b0; i_req1 = 1'b0;
    wait_busy(1'b0, "fresh_end");
    cyc(3);

    check("bytes_left", 32'(exp_bytes.size()), 32'h0);
    check("dones_left", 32'(exp_done.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
